m_bcd_scan_display: RTL and testbench

//  Drives a 3-digit multiplexed common-anode 7-segment display from the 12-bit packed
//  BCD word produced by the binary-to-BCD decoder.

---
 rtl/m_bcd_scan_display.sv | 130 +++++++++++++
 tb/tb_m_bcd_scan_display.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/m_bcd_scan_display.sv
// 3-digit multiplexed common-anode 7-segment driver for packed BCD.
// Frame-synchronous value update, dead-time between digits, leading-zero blanking.
module m_bcd_scan_display #(
   parameter int DIV   = 50000,
   parameter int BLANK = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] bcd_in,
   input  logic        load,
   input  logic        lzb_en,
   output logic [7:0]  seg,
   output logic [2:0]  dig,
   output logic        frame_done
);

   localparam int MAXC = (DIV > BLANK) ? DIV : BLANK;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] DIV_L = CW'(DIV - 1);
   localparam logic [CW-1:0] BLK_L = CW'(BLANK - 1);

   typedef enum logic {
      S_SCAN,
      S_BLANK
   } state_t;

   state_t      state, nxt_state;
   logic [1:0]  idx, nxt_idx;
   logic [CW-1:0] cnt, nxt_cnt;
   logic [11:0] shadow, disp, nxt_disp;
   logic        boundary;
   logic [3:0]  nib;
   logic        h0, t0, blk;
   logic [2:0]  dig_sel;

   function automatic logic [7:0] enc(input logic [3:0] n);
      logic [7:0] s;
      case (n)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h98;
         default: s = 8'hBF;
      endcase
      return s;
   endfunction

   always_comb begin
      nxt_state = state;
      nxt_idx   = idx;
      nxt_cnt   = cnt + CW'(1);
      boundary  = 1'b0;
      unique case (state)
         S_SCAN: begin
            if (cnt == DIV_L) begin
               nxt_state = S_BLANK;
               nxt_cnt   = '0;
            end
         end
         S_BLANK: begin
            if (cnt == BLK_L) begin
               nxt_state = S_SCAN;
               nxt_cnt   = '0;
               nxt_idx   = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
               boundary  = (idx == 2'd2);
            end
         end
      endcase
      // a load on the boundary edge goes straight to the display
      nxt_disp = boundary ? (load ? bcd_in : shadow) : disp;
   end

   always_comb begin
      nib     = nxt_disp[3:0];
      dig_sel = 3'b110;
      unique case (nxt_idx)
         2'd1: begin
            nib     = nxt_disp[7:4];
            dig_sel = 3'b101;
         end
         2'd2: begin
            nib     = nxt_disp[11:8];
            dig_sel = 3'b011;
         end
         default: begin
            nib     = nxt_disp[3:0];
            dig_sel = 3'b110;
         end
      endcase
      h0  = (nxt_disp[11:8] == 4'd0);
      t0  = (nxt_disp[7:4] == 4'd0);
      blk = lzb_en && (((nxt_idx == 2'd2) && h0) ||
                       ((nxt_idx == 2'd1) && h0 && t0));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_BLANK;
         idx        <= 2'd2;
         cnt        <= '0;
         shadow     <= '0;
         disp       <= '0;
         seg        <= 8'hFF;
         dig        <= 3'b111;
         frame_done <= 1'b0;
      end else begin
         state      <= nxt_state;
         idx        <= nxt_idx;
         cnt        <= nxt_cnt;
         disp       <= nxt_disp;
         frame_done <= boundary;
         if (load)
            shadow <= bcd_in;
         if (nxt_state == S_SCAN) begin
            seg <= blk ? 8'hFF : enc(nib);
            dig <= dig_sel;
         end else begin
            seg <= 8'hFF;
            dig <= 3'b111;
         end
      end
   end

endmodule

// File: tb/tb_m_bcd_scan_display.sv
// Bench for m_bcd_scan_display: directed scenarios then random traffic,
// checked against a frame/slot timing model derived from cycle count.
module tb_m_bcd_scan_display;

   localparam int DIV   = 4;
   localparam int BLANK = 2;
   localparam int SLOT  = DIV + BLANK;
   localparam int FRAME = 3 * SLOT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [11:0] bcd_in = '0;
   logic        load = 1'b0;
   logic        lzb_en = 1'b0;
   logic [7:0]  seg;
   logic [2:0]  dig;
   logic        frame_done;

   int total = 0;
   int bad = 0;
   int k = 0;
   logic [11:0] sh_m = '0;
   logic [11:0] dp_m = '0;

   m_bcd_scan_display #(.DIV(DIV), .BLANK(BLANK)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bcd_in(bcd_in),
      .load(load),
      .lzb_en(lzb_en),
      .seg(seg),
      .dig(dig),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] enc(input logic [3:0] n);
      logic [7:0] t [16];
      t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h98, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
      return t[n];
   endfunction

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      k    = 0;
      sh_m = '0;
      dp_m = '0;
   endtask

   task automatic step(input string tag);
      logic [7:0] es;
      logic [2:0] ed;
      logic [7:0] ef;
      logic [3:0] nib;
      logic h0, t0, blk;
      int s, idx;
      @(posedge clk);
      es = 8'hFF;
      ed = 3'b111;
      ef = 8'd0;
      if (rst_n) begin
         k++;
         s = k - BLANK;
         if (load)
            sh_m = bcd_in;
         if (s >= 0 && (s % FRAME) == 0) begin
            dp_m = sh_m;
            ef   = 8'd1;
         end
         if (s >= 0 && (s % SLOT) < DIV) begin
            idx = (s % FRAME) / SLOT;
            nib = dp_m[idx*4 +: 4];
            h0  = (dp_m[11:8] == 4'd0);
            t0  = (dp_m[7:4] == 4'd0);
            blk = lzb_en && ((idx == 2 && h0) || (idx == 1 && h0 && t0));
            es  = blk ? 8'hFF : enc(nib);
            ed[idx] = 1'b0;
         end
      end
      #1;
      chk({tag, "_seg"}, seg, es);
      chk({tag, "_dig"}, {5'd0, dig}, {5'd0, ed});
      chk({tag, "_fd"}, {7'd0, frame_done}, ef);
   endtask

   task automatic steps(input string tag, input int n);
      for (int i = 0; i < n; i++)
         step(tag);
   endtask

   function automatic bit next_is_boundary();
      return (k + 1 - BLANK) >= 0 && ((k + 1 - BLANK) % FRAME) == 0;
   endfunction

   task automatic to_pre_boundary(input string tag);
      int guard;
      guard = 0;
      while (!next_is_boundary() && guard < 2 * FRAME) begin
         step(tag);
         guard++;
      end
   endtask

   task automatic pulse_load(input string tag, input logic [11:0] v);
      bcd_in = v;
      load   = 1'b1;
      step(tag);
      load   = 1'b0;
   endtask

   task automatic async_reset(input string tag);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk({tag, "_aseg"}, seg, 8'hFF);
      chk({tag, "_adig"}, {5'd0, dig}, 8'h07);
      chk({tag, "_afd"}, {7'd0, frame_done}, 8'h00);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [11:0] v;
      int rst_at;

      // 1: reset held, then release
      #1;
      async_reset("s1");
      steps("s1_hold", 3);
      release_reset();
      step("s1_e1");
      step("s1_e2");
      chk("s1_c0", seg, 8'hC0);
      chk("s1_dig", {5'd0, dig}, 8'h06);
      chk("s1_fd", {7'd0, frame_done}, 8'h01);

      // 2: plain 123
      lzb_en = 1'b0;
      pulse_load("s2", 12'h123);
      to_pre_boundary("s2");
      step("s2_b");
      chk("s2_ones", seg, 8'hB0);
      steps("s2", FRAME - 1);

      // 3: leading-zero blanking
      lzb_en = 1'b1;
      pulse_load("s3a", 12'h007);
      to_pre_boundary("s3a");
      step("s3a_b");
      chk("s3a_ones", seg, 8'hF8);
      steps("s3a", FRAME - 1);
      pulse_load("s3b", 12'h000);
      to_pre_boundary("s3b");
      steps("s3b", FRAME);
      pulse_load("s3c", 12'h105);
      to_pre_boundary("s3c");
      steps("s3c_b", SLOT + 1);
      chk("s3c_tens", seg, 8'hC0);
      steps("s3c", FRAME - SLOT - 1);

      // 4: invalid nibble shows dash
      lzb_en = 1'b0;
      pulse_load("s4", 12'h0A5);
      to_pre_boundary("s4");
      steps("s4_b", SLOT + 1);
      chk("s4_tens", seg, 8'hBF);
      steps("s4", FRAME - SLOT - 1);

      // 5: mid-frame load waits, boundary load bypasses
      to_pre_boundary("s5");
      steps("s5", 3);
      pulse_load("s5_mid", 12'h456);
      to_pre_boundary("s5_old");
      bcd_in = 12'h789;
      load   = 1'b1;
      step("s5_b");
      load   = 1'b0;
      chk("s5_byp", seg, 8'h98);
      steps("s5", FRAME);

      // 6: async reset during the tens slot
      while (!((k - BLANK) >= 0 && ((k - BLANK) % FRAME) >= SLOT + 1 &&
               ((k - BLANK) % FRAME) < SLOT + DIV))
         step("s6_wait");
      async_reset("s6");
      steps("s6_hold", 2);
      release_reset();
      steps("s6", 2);
      chk("s6_c0", seg, 8'hC0);
      steps("s6", FRAME);

      // random traffic with one mid-run reset
      rst_at = 200 + int'($urandom_range(0, 150));
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            v[3:0]  = 4'($urandom_range(0, 9));
            v[7:4]  = 4'($urandom_range(0, 9));
            v[11:8] = 4'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 9));
         end else begin
            v = 12'($urandom);
         end
         bcd_in = v;
         load   = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 19) == 0)
            lzb_en = ~lzb_en;
         if (i == rst_at) begin
            load = 1'b0;
            async_reset("rnd_rst");
            steps("rnd_hold", 2);
            release_reset();
         end
         step("rnd");
      end
      load = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
